// File: rtl/calendar_date_counter_pkg.sv
// Shared calendar definitions: calendar and FSM enums, date payload struct,
// modulo constants, month-length table and leap-year derivation.
package calendar_date_counter_pkg;

    typedef enum logic {
        GREGORIAN = 1'b0,
        SYMMETRY  = 1'b1
    } cal_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MOD400 = 2'd1,
        ST_MODSYM = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam int unsigned DAY_W        = 6;
    localparam int unsigned MONTH_W      = 4;
    localparam int unsigned REM_W        = 9;    // holds remainders below 400 and 293
    localparam int unsigned GREG_CYCLE   = 400;
    localparam int unsigned SYM_MOD      = 293;
    localparam int unsigned SYM_MUL      = 52;
    localparam int unsigned SYM_OFF      = 146;
    localparam int unsigned LOAD_LAT     = 33;
    localparam int unsigned RESET_YEAR   = 2000;
    localparam int unsigned RESET_SYMRES = 131;  // (52*2000+146) mod 293

    // Date fields that travel together between shadow and committed state
    typedef struct packed {
        cal_t                 cal;
        logic [MONTH_W-1:0]   month;
        logic [DAY_W-1:0]     day;
    } date_t;

    // Month length; 0 for an out-of-range month so any day compares as invalid
    function automatic logic [DAY_W-1:0] monthLen(input logic [MONTH_W-1:0] m,
                                                  input cal_t               cal,
                                                  input logic               lp);
        logic [DAY_W-1:0] len;
        len = '0;
        if (cal == GREGORIAN) begin
            case (m)
                4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 6'd31;
                4'd4, 4'd6, 4'd9, 4'd11:                    len = 6'd30;
                4'd2:                                       len = lp ? 6'd29 : 6'd28;
                default:                                    len = '0;
            endcase
        end else begin
            case (m)
                4'd2, 4'd5, 4'd8, 4'd11:                    len = 6'd35;
                4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd10:  len = 6'd28;
                4'd12:                                      len = lp ? 6'd35 : 6'd28;
                default:                                    len = '0;
            endcase
        end
        return len;
    endfunction

    // Leap flag from the maintained residues (year mod 400, symmetry residue)
    function automatic logic isLeap(input cal_t             cal,
                                    input logic [REM_W-1:0] y400,
                                    input logic [REM_W-1:0] symres);
        logic lp;
        if (cal == GREGORIAN) begin
            lp = (y400[1:0] == 2'b00) && (y400 != 9'd100) && (y400 != 9'd200)
                 && (y400 != 9'd300);
        end else begin
            lp = (symres < REM_W'(SYM_MUL));
        end
        return lp;
    endfunction

endpackage

// File: rtl/calendar_date_counter_seq_mod.sv
// Sequential restoring-division remainder unit, one quotient bit per cycle.
// Ports: clk, reset (sync, active-high); start_i loads dividend_i/divisor_i and
// the number of significant dividend bits nbits_i; done_o pulses one cycle once
// rem_o holds dividend mod divisor (nbits_i cycles after start). rem_o is held
// until the next start.
module seq_mod #(
    parameter int unsigned DW = 18,
    parameter int unsigned RW = 9,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [RW-1:0] divisor_i,
    input  logic [CW-1:0] nbits_i,
    output logic          done_o,
    output logic [RW-1:0] rem_o
);

    logic [DW-1:0] dvd_q, dvd_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [RW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [RW:0]   trial_c;

    // Shift the next dividend bit into the partial remainder, subtract if it fits
    always_comb begin
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        trial_c = {rem_q, dvd_q[DW-1]};
        if (start_i) begin
            // Left-align the significant bits so only nbits_i iterations are needed
            dvd_d = dividend_i << (CW'(DW) - nbits_i);
            rem_d = '0;
            div_d = divisor_i;
            cnt_d = nbits_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (trial_c >= {1'b0, div_q}) begin
                rem_d = RW'(trial_c - {1'b0, div_q});
            end else begin
                rem_d = RW'(trial_c);
            end
            dvd_d = {dvd_q[DW-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/calendar_date_counter.sv
// Calendar date counter (Gregorian / Symmetry) with validated date load.
// Ports: clk, reset (sync, active-high); tick advances one day; load with
// loadDay/loadMonth/loadYear/calSel requests a new date, validated over a
// 33-cycle busy window (year mod 400, symmetry residue, range check).
// Outputs dayOfMonth, month, year, leap, busy, valid, err (reject pulse),
// yearInc (year rollover pulse).
module calendar_date_counter
    import calendar_date_counter_pkg::*;
#(
    parameter int unsigned YEAR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              load,
    input  logic [5:0]        loadDay,
    input  logic [3:0]        loadMonth,
    input  logic [YEAR_W-1:0] loadYear,
    input  logic              calSel,
    output logic [5:0]        dayOfMonth,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              leap,
    output logic              busy,
    output logic              valid,
    output logic              err,
    output logic              yearInc
);

    localparam int unsigned SYM_W = YEAR_W + 6;         // width of 52*year+146
    localparam int unsigned NB_W  = $clog2(SYM_W + 1);

    state_t             state_q, state_d;
    date_t              cur_q, cur_d;
    logic [YEAR_W-1:0]  year_q, year_d;
    logic [REM_W-1:0]   y400_q, y400_d;
    logic [REM_W-1:0]   symres_q, symres_d;
    logic               leap_q, leap_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               yinc_q, yinc_d;
    date_t              sh_q, sh_d;
    logic [YEAR_W-1:0]  sh_year_q, sh_year_d;
    logic [REM_W-1:0]   sh_y400_q, sh_y400_d;
    logic [REM_W-1:0]   sh_sym_q, sh_sym_d;

    logic               mod_start_c;
    logic [SYM_W-1:0]   mod_dvd_c;
    logic [REM_W-1:0]   mod_div_c;
    logic [NB_W-1:0]    mod_nbits_c;
    logic               mod_done;
    logic [REM_W-1:0]   mod_rem;
    logic [DAY_W-1:0]   cur_len_c;
    logic [DAY_W-1:0]   sh_len_c;
    logic               sh_leap_c;

    // Shared divider operands: year mod 400 when started from RUN, symmetry residue otherwise
    always_comb begin
        if (state_q == ST_RUN) begin
            mod_dvd_c   = SYM_W'(loadYear);
            mod_div_c   = REM_W'(GREG_CYCLE);
            mod_nbits_c = NB_W'(YEAR_W);
        end else begin
            mod_dvd_c   = SYM_W'(SYM_W'(SYM_MUL) * SYM_W'(sh_year_q) + SYM_W'(SYM_OFF));
            mod_div_c   = REM_W'(SYM_MOD);
            mod_nbits_c = NB_W'(SYM_W);
        end
    end

    seq_mod #(
        .DW (SYM_W),
        .RW (REM_W),
        .CW (NB_W)
    ) u_seq_mod (
        .clk        (clk),
        .reset      (reset),
        .start_i    (mod_start_c),
        .dividend_i (mod_dvd_c),
        .divisor_i  (mod_div_c),
        .nbits_i    (mod_nbits_c),
        .done_o     (mod_done),
        .rem_o      (mod_rem)
    );

    // Next-state: day advance, load capture, residue computation, validation
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        year_d      = year_q;
        y400_d      = y400_q;
        symres_d    = symres_q;
        sh_d        = sh_q;
        sh_year_d   = sh_year_q;
        sh_y400_d   = sh_y400_q;
        sh_sym_d    = sh_sym_q;
        err_d       = 1'b0;
        yinc_d      = 1'b0;
        mod_start_c = 1'b0;
        cur_len_c   = monthLen(cur_q.month, cur_q.cal, leap_q);
        sh_leap_c   = isLeap(sh_q.cal, sh_y400_q, sh_sym_q);
        sh_len_c    = monthLen(sh_q.month, sh_q.cal, sh_leap_c);

        case (state_q)
            ST_RUN: begin
                if (load) begin
                    sh_d        = '{cal: cal_t'(calSel), month: loadMonth, day: loadDay};
                    sh_year_d   = loadYear;
                    mod_start_c = 1'b1;
                    state_d     = ST_MOD400;
                end else if (tick) begin
                    if (cur_q.day < cur_len_c) begin
                        cur_d.day = cur_q.day + 6'd1;
                    end else begin
                        cur_d.day = 6'd1;
                        if (cur_q.month == 4'd12) begin
                            cur_d.month = 4'd1;
                            yinc_d      = 1'b1;
                            year_d      = year_q + YEAR_W'(1);
                            if (&year_q) begin
                                // Year wraps to 0: reseed residues to their year-0 values
                                y400_d   = '0;
                                symres_d = REM_W'(SYM_OFF);
                            end else begin
                                y400_d = (y400_q == REM_W'(GREG_CYCLE - 1)) ? '0
                                         : y400_q + REM_W'(1);
                                symres_d = (symres_q >= REM_W'(SYM_MOD - SYM_MUL))
                                           ? REM_W'(symres_q - REM_W'(SYM_MOD - SYM_MUL))
                                           : REM_W'(symres_q + REM_W'(SYM_MUL));
                            end
                        end else begin
                            cur_d.month = cur_q.month + 4'd1;
                        end
                    end
                end
            end
            ST_MOD400: begin
                if (mod_done) begin
                    sh_y400_d   = mod_rem;
                    mod_start_c = 1'b1;
                    state_d     = ST_MODSYM;
                end
            end
            ST_MODSYM: begin
                if (mod_done) begin
                    sh_sym_d = mod_rem;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_RUN;
                if ((sh_q.month == 4'd0) || (sh_q.month > 4'd12) ||
                    (sh_q.day == 6'd0) || (sh_q.day > sh_len_c)) begin
                    err_d = 1'b1;
                end else begin
                    cur_d    = sh_q;
                    year_d   = sh_year_q;
                    y400_d   = sh_y400_q;
                    symres_d = sh_sym_q;
                end
            end
            default: state_d = ST_RUN;
        endcase

        leap_d  = isLeap(cur_d.cal, y400_d, symres_d);
        busy_d  = (state_d != ST_RUN);
        valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            cur_q     <= '{cal: GREGORIAN, month: 4'd1, day: 6'd1};
            year_q    <= YEAR_W'(RESET_YEAR);
            y400_q    <= '0;
            symres_q  <= REM_W'(RESET_SYMRES);
            leap_q    <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            err_q     <= 1'b0;
            yinc_q    <= 1'b0;
            sh_q      <= '0;
            sh_year_q <= '0;
            sh_y400_q <= '0;
            sh_sym_q  <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            year_q    <= year_d;
            y400_q    <= y400_d;
            symres_q  <= symres_d;
            leap_q    <= leap_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            yinc_q    <= yinc_d;
            sh_q      <= sh_d;
            sh_year_q <= sh_year_d;
            sh_y400_q <= sh_y400_d;
            sh_sym_q  <= sh_sym_d;
        end
    end

    assign dayOfMonth = cur_q.day;
    assign month      = cur_q.month;
    assign year       = year_q;
    assign leap       = leap_q;
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign yearInc    = yinc_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Self-checking bench for calendar_date_counter: a calendar-level reference
// model compared every cycle, directed scenarios with literal expectations,
// then randomized tick/load/reset traffic.
`timescale 1ns/1ps
module tb_calendar_date_counter;

    localparam int unsigned YW  = 12;
    localparam int          LAT = 33;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          load = 1'b0;
    logic [5:0]    loadDay = '0;
    logic [3:0]    loadMonth = '0;
    logic [YW-1:0] loadYear = '0;
    logic          calSel = 1'b0;
    logic [5:0]    dayOfMonth;
    logic [3:0]    month;
    logic [YW-1:0] year;
    logic          leap, busy, valid, err, yearInc;

    always #5 clk = ~clk;

    calendar_date_counter #(.YEAR_W(YW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .loadDay    (loadDay),
        .loadMonth  (loadMonth),
        .loadYear   (loadYear),
        .calSel     (calSel),
        .dayOfMonth (dayOfMonth),
        .month      (month),
        .year       (year),
        .leap       (leap),
        .busy       (busy),
        .valid      (valid),
        .err        (err),
        .yearInc    (yearInc)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model (calendar arithmetic) ----------------
    function automatic int ref_leap(input int y, input int cal);
        if (cal == 0) return ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0) ? 1 : 0;
        return (((52 * y + 146) % 293) < 52) ? 1 : 0;
    endfunction

    function automatic int ref_len(input int mo, input int cal, input int y);
        if (mo < 1 || mo > 12) return 0;
        if (cal == 0) begin
            if (mo == 2) return ref_leap(y, 0) ? 29 : 28;
            if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
            return 31;
        end
        if (mo % 3 == 2) return 35;
        if (mo == 12 && ref_leap(y, 1) == 1) return 35;
        return 28;
    endfunction

    int m_day, m_mon, m_year, m_cal, m_busy, m_err, m_yinc;
    int p_day, p_mon, p_year, p_cal;

    always @(posedge clk) begin
        m_err  = 0;
        m_yinc = 0;
        if (reset) begin
            m_day = 1; m_mon = 1; m_year = 2000; m_cal = 0; m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (p_day >= 1 && p_day <= ref_len(p_mon, p_cal, p_year)) begin
                    m_day = p_day; m_mon = p_mon; m_year = p_year; m_cal = p_cal;
                end else begin
                    m_err = 1;
                end
            end
        end else if (load) begin
            p_day = int'(loadDay); p_mon = int'(loadMonth);
            p_year = int'(loadYear); p_cal = int'(calSel);
            m_busy = LAT;
        end else if (tick) begin
            if (m_day < ref_len(m_mon, m_cal, m_year)) m_day++;
            else begin
                m_day = 1;
                if (m_mon == 12) begin
                    m_mon = 1;
                    m_year = (m_year + 1) % 4096;
                    m_yinc = 1;
                end else m_mon++;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("day",     int'(dayOfMonth), m_day);
            check("month",   int'(month), m_mon);
            check("year",    int'(year), m_year);
            check("leap",    int'(leap), ref_leap(m_year, m_cal));
            check("busy",    int'(busy), (m_busy > 0) ? 1 : 0);
            check("valid",   int'(valid), (m_busy == 0) ? 1 : 0);
            check("err",     int'(err), m_err);
            check("yearInc", int'(yearInc), m_yinc);
            check("y400",    int'(dut.y400_q), m_year % 400);
            check("symres",  int'(dut.symres_q), (52 * m_year + 146) % 293);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit t, input bit l, input int d, input int mo,
                         input int y, input bit c, input bit r);
        @(negedge clk);
        tick      = t;
        load      = l;
        loadDay   = 6'(d);
        loadMonth = 4'(mo);
        loadYear  = YW'(y);
        calSel    = c;
        reset     = r;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Issue a load, then observe 40 cycles counting busy and err
    task automatic do_load(input int d, input int mo, input int y, input bit c,
                           output int busy_n, output int err_n);
        drive(0, 1, d, mo, y, c, 0);
        busy_n = 0;
        err_n  = 0;
        repeat (40) begin
            idle();
            busy_n += int'(busy);
            err_n  += int'(err);
        end
    endtask

    task automatic tick_once();
        drive(1, 0, 0, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        int bn, en, b24;
        int d, mo, y, r;
        bit c;

        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        idle();

        // Reset values
        check("rst_day",   int'(dayOfMonth), 1);
        check("rst_month", int'(month), 1);
        check("rst_year",  int'(year), 2000);
        check("rst_leap",  int'(leap), 1);
        check("rst_valid", int'(valid), 1);
        check("rst_busy",  int'(busy), 0);
        check("rst_err",   int'(err), 0);

        // Gregorian 28/2/1900: non-leap century, rolls into March
        do_load(28, 2, 1900, 0, bn, en);
        check("g1900_busy_cycles", bn, 33);
        check("g1900_err", en, 0);
        check("g1900_leap", int'(leap), 0);
        tick_once();
        check("g1900_tick_day", int'(dayOfMonth), 1);
        check("g1900_tick_month", int'(month), 3);
        check("g1900_tick_year", int'(year), 1900);

        // 31/12/1999 -> 1/1/2000 with yearInc, then reject 29/2/2100
        do_load(31, 12, 1999, 0, bn, en);
        tick_once();
        check("g2000_day", int'(dayOfMonth), 1);
        check("g2000_month", int'(month), 1);
        check("g2000_year", int'(year), 2000);
        check("g2000_leap", int'(leap), 1);
        check("g2000_yearinc", int'(yearInc), 1);
        do_load(29, 2, 2100, 0, bn, en);
        check("g2100_err_pulses", en, 1);
        check("g2100_busy_cycles", bn, 33);
        check("g2100_keep_day", int'(dayOfMonth), 1);
        check("g2100_keep_year", int'(year), 2000);

        // Symmetry 35/12/2004 leap, rollover to 2005, 35/12/2005 rejected
        do_load(35, 12, 2004, 1, bn, en);
        check("s2004_err", en, 0);
        check("s2004_day", int'(dayOfMonth), 35);
        check("s2004_leap", int'(leap), 1);
        tick_once();
        check("s2005_day", int'(dayOfMonth), 1);
        check("s2005_month", int'(month), 1);
        check("s2005_year", int'(year), 2005);
        check("s2005_leap", int'(leap), 0);
        do_load(35, 12, 2005, 1, bn, en);
        check("s2005_err_pulses", en, 1);

        // Year wrap 4095 -> 0
        do_load(31, 12, 4095, 0, bn, en);
        tick_once();
        check("wrap_year", int'(year), 0);
        check("wrap_day", int'(dayOfMonth), 1);
        check("wrap_month", int'(month), 1);
        check("wrap_leap", int'(leap), 1);
        check("wrap_symres", int'(dut.symres_q), 146);
        check("wrap_y400", int'(dut.y400_q), 0);

        // Tick/load while busy ignored, reset mid-load restores defaults
        drive(0, 1, 10, 5, 2020, 0, 0);
        b24 = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 5)       drive(1, 1, 15, 6, 2021, 0, 0);
            else if (k == 20) drive(0, 1, 3, 3, 2003, 1, 0);
            else if (k == 25) drive(0, 0, 0, 0, 0, 0, 1);
            else              idle();
            if (k == 24) b24 = int'(busy);
        end
        idle();
        check("abort_busy_before_reset", b24, 1);
        check("abort_day", int'(dayOfMonth), 1);
        check("abort_month", int'(month), 1);
        check("abort_year", int'(year), 2000);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 1);
        repeat (40) idle();
        check("abort_no_late_commit_year", int'(year), 2000);

        // Randomized traffic
        repeat (4000) begin
            r = int'($urandom_range(0, 399));
            if (r == 0) begin
                drive(0, 0, 0, 0, 0, 0, 1);
            end else if (r < 16) begin
                d  = int'($urandom_range(0, 36));
                mo = int'($urandom_range(0, 13));
                y  = int'($urandom_range(0, 4095));
                c  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) begin
                    mo = 12;
                    d  = int'($urandom_range(27, 36));
                end
                if ($urandom_range(0, 5) == 0) y = 4095;
                drive(1'($urandom_range(0, 1)), 1, d, mo, y, c, 0);
            end else begin
                drive(r < 300, 0, 0, 0, 0, 0, 0);
            end
        end
        repeat (40) idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
